// File: rtl/tt_pkg.sv
// tt_pkg: settle-state encoding and address-width defaults shared by the
// select controller and the branch mux.
package tt_pkg;
    localparam int UM_W_DEF = 5;
    localparam int BR_W_DEF = 5;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLING = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;
endpackage

// File: rtl/tt_sync_edge.sv
// tt_sync_edge: multi-flop pad synchroniser; with EDGE set, the output is a
// one-cycle pulse on each rising edge of the synchronised level instead.
module tt_sync_edge #(
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_q
);
    logic [STAGES-1:0] r_sh;
    logic              r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh <= '0;
            r_d  <= 1'b0;
        end else begin
            r_sh <= {r_sh[STAGES-2:0], i_async};
            r_d  <= r_sh[STAGES-1];
        end
    end

    assign o_q = EDGE ? (r_sh[STAGES-1] & ~r_d) : r_sh[STAGES-1];
endmodule

// File: rtl/tt_sel_ctrl.sv
// tt_sel_ctrl: two-level (branch, module) design-select counter driven by
// asynchronous pads, with a settle window gating the user-module enable.
module tt_sel_ctrl
    import tt_pkg::*;
#(
    parameter int G_X         = 16,
    parameter int G_Y         = 1,
    parameter int UM_W        = UM_W_DEF,
    parameter int BR_W        = BR_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4,
    parameter int WRAP        = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pad_sel_rst_n,
    input  logic            pad_sel_inc,
    input  logic            pad_ena,
    output logic [UM_W-1:0] addr_um,
    output logic [BR_W-1:0] addr_br,
    output logic [G_Y-1:0]  br_sel,
    output logic            ena_out,
    output logic            busy,
    output logic            at_last
);
    localparam logic [UM_W-1:0] UM_LAST     = UM_W'(G_X - 1);
    localparam logic [BR_W-1:0] BR_LAST     = BR_W'(G_Y - 1);
    localparam logic [7:0]      CNT_INIT    = 8'(SETTLE - 1);
    localparam logic            AT_LAST_RST = (G_X == 1) && (G_Y == 1);
    localparam logic            WRAP_EN     = (WRAP != 0);

    logic            w_s_rst_n, w_inc_edge, w_s_ena;
    logic            w_evt, w_load, w_um_last, w_br_last, w_at_last;
    logic [UM_W-1:0] w_um_nxt;
    logic [BR_W-1:0] w_br_nxt;
    logic [G_Y-1:0]  w_br_sel;
    logic [1:0]      w_state_nxt;
    logic [7:0]      w_cnt_nxt;

    logic [UM_W-1:0] r_um;
    logic [BR_W-1:0] r_br;
    logic [G_Y-1:0]  r_br_sel;
    logic            r_at_last, r_ena, r_busy;
    logic [1:0]      r_state;
    logic [7:0]      r_cnt;

    tt_sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_rst (
        .clk(clk), .rst_n(rst_n), .i_async(pad_sel_rst_n), .o_q(w_s_rst_n));
    tt_sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_inc (
        .clk(clk), .rst_n(rst_n), .i_async(pad_sel_inc), .o_q(w_inc_edge));
    tt_sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_ena (
        .clk(clk), .rst_n(rst_n), .i_async(pad_ena), .o_q(w_s_ena));

    // Select reset dominates the increment; the module counter carries into the branch.
    always_comb begin
        w_um_last   = (r_um == UM_LAST);
        w_br_last   = (r_br == BR_LAST);
        w_evt       = !w_s_rst_n || w_inc_edge;
        w_um_nxt    = !w_s_rst_n ? '0 :
                      !w_inc_edge ? r_um :
                      !w_um_last ? r_um + 1'b1 :
                      (w_br_last && !WRAP_EN) ? r_um : '0;
        w_br_nxt    = !w_s_rst_n ? '0 :
                      (!w_inc_edge || !w_um_last) ? r_br :
                      !w_br_last ? r_br + 1'b1 :
                      WRAP_EN ? '0 : r_br;
        w_br_sel    = G_Y'(1) << w_br_nxt;
        w_at_last   = (w_um_nxt == UM_LAST) && (w_br_nxt == BR_LAST);
        w_load      = w_s_ena && (w_evt || (r_state == ST_IDLE));
        w_state_nxt = !w_s_ena ? ST_IDLE :
                      w_load ? ST_SETTLING :
                      (r_state == ST_SETTLING && r_cnt == '0) ? ST_ACTIVE : r_state;
        w_cnt_nxt   = w_load ? CNT_INIT :
                      (r_state == ST_SETTLING && r_cnt != '0) ? r_cnt - 8'd1 : r_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_um      <= '0;
            r_br      <= '0;
            r_br_sel  <= G_Y'(1);
            r_at_last <= AT_LAST_RST;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ena     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_um      <= w_um_nxt;
            r_br      <= w_br_nxt;
            r_br_sel  <= w_br_sel;
            r_at_last <= w_at_last;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ena     <= (w_state_nxt == ST_ACTIVE);
            r_busy    <= (w_state_nxt == ST_SETTLING);
        end
    end

    assign addr_um = r_um;
    assign addr_br = r_br;
    assign br_sel  = r_br_sel;
    assign at_last = r_at_last;
    assign ena_out = r_ena;
    assign busy    = r_busy;
endmodule

// File: tb/tb_tt_sel_ctrl.sv
// tb_tt_sel_ctrl: scoreboard bench for a 16x2 grid; the WRAP=1 instance is
// monitored on every output change, the WRAP=0 twin is spot-checked.
module tb_tt_sel_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       pad_sel_rst_n = 1'b1, pad_sel_inc = 1'b0, pad_ena = 1'b0;
    logic [4:0] addr_um, addr_br, u0_um, u0_br;
    logic [1:0] br_sel, u0_br_sel;
    logic       ena_out, busy, at_last, u0_ena, u0_busy, u0_last;

    typedef struct { int cyc; logic [12:0] v; } exp_t;
    exp_t        aq[$], eq[$];
    int          cyc = 0, checks = 0, failures = 0, ebr = 0, eum = 0, n = 0;
    bit          mon_on = 1'b0, first = 1'b1;
    logic [12:0] pa = '0, pe = '0, a, e;

    tt_sel_ctrl #(.G_X(16), .G_Y(2), .UM_W(5), .BR_W(5), .SYNC_STAGES(2), .SETTLE(4), .WRAP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .pad_sel_rst_n(pad_sel_rst_n), .pad_sel_inc(pad_sel_inc),
        .pad_ena(pad_ena), .addr_um(addr_um), .addr_br(addr_br), .br_sel(br_sel),
        .ena_out(ena_out), .busy(busy), .at_last(at_last));

    tt_sel_ctrl #(.G_X(16), .G_Y(2), .UM_W(5), .BR_W(5), .SYNC_STAGES(2), .SETTLE(4), .WRAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .pad_sel_rst_n(pad_sel_rst_n), .pad_sel_inc(pad_sel_inc),
        .pad_ena(pad_ena), .addr_um(u0_um), .addr_br(u0_br), .br_sel(u0_br_sel),
        .ena_out(u0_ena), .busy(u0_busy), .at_last(u0_last));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] abun(input int br, input int um);
        return {5'(br), 5'(um), (br == 0) ? 2'b01 : 2'b10, (br == 1 && um == 15)};
    endfunction

    task automatic adv();
        if (eum < 15) eum++;
        else begin
            eum = 0;
            ebr = (ebr == 1) ? 0 : ebr + 1;
        end
    endtask

    task automatic push(input bit k, input int c, input logic [12:0] v);
        exp_t x;
        x.cyc = c;
        x.v   = v;
        if (k) eq.push_back(x);
        else aq.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h @cyc %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input bit k, input logic [12:0] act);
        exp_t x;
        checks++;
        if ((k ? eq.size() : aq.size()) == 0) begin
            failures++;
            $display("FAIL %s unexpected change got=%0h @cyc %0d", k ? "ena" : "addr", act, cyc);
            return;
        end
        if (k) x = eq.pop_front();
        else x = aq.pop_front();
        if (act !== x.v || (x.cyc >= 0 && x.cyc != cyc)) begin
            failures++;
            $display("FAIL %s got=%0h @cyc %0d want=%0h @cyc %0d", k ? "ena" : "addr", act, cyc, x.v, x.cyc);
        end
    endtask

    // Every change of the address bundle or of {busy, ena_out} consumes one expectation.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        if (mon_on) begin
            a = {addr_br, addr_um, br_sel, at_last};
            e = {11'd0, busy, ena_out};
            if (first || a !== pa) pop_cmp(1'b0, a);
            if (first || e !== pe) pop_cmp(1'b1, e);
            pa    = a;
            pe    = e;
            first = 1'b0;
        end
    end

    task automatic inc_pulse(input bit live, input bit settle);
        int m;
        @(negedge clk);
        m = cyc;
        pad_sel_inc = 1'b1;
        if (live) begin
            adv();
            push(1'b0, m + 3, abun(ebr, eum));
            if (settle) begin
                push(1'b1, m + 3, 13'b10);
                push(1'b1, m + 7, 13'b01);
            end
        end
        repeat (3) @(negedge clk);
        pad_sel_inc = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired @cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        push(1'b0, -1, abun(0, 0));
        push(1'b1, -1, 13'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 1; i <= 32; i++) begin
            inc_pulse(1'b1, 1'b0);
            if (i == 15) chk("p15_addr", {addr_br, addr_um}, {5'd0, 5'd15});
            if (i == 16) chk("p16_addr", {addr_br, addr_um}, {5'd1, 5'd0});
            if (i == 16) chk("p16_br_sel", br_sel, 2'b10);
            if (i == 31) chk("p31_at_last", at_last, 1'b1);
            if (i == 31) chk("p31_u0_last", u0_last, 1'b1);
            if (i == 32) chk("p32_wrap_addr", {addr_br, addr_um}, {5'd0, 5'd0});
            if (i == 32) chk("p32_sat_addr", {u0_br, u0_um}, {5'd1, 5'd15});
            if (i == 32) chk("p32_sat_last", u0_last, 1'b1);
            if (i == 32) chk("p32_sat_br_sel", u0_br_sel, 2'b10);
        end

        @(negedge clk);
        n = cyc;
        pad_ena = 1'b1;
        push(1'b1, n + 3, 13'b10);
        push(1'b1, n + 7, 13'b01);
        repeat (10) @(negedge clk);
        inc_pulse(1'b1, 1'b1);
        repeat (4) @(negedge clk);

        @(negedge clk);
        n = cyc;
        pad_sel_rst_n = 1'b0;
        eum = 0;
        ebr = 0;
        push(1'b0, n + 3, abun(0, 0));
        push(1'b1, n + 3, 13'b10);
        repeat (3) @(negedge clk);
        inc_pulse(1'b0, 1'b0);
        inc_pulse(1'b0, 1'b0);
        chk("hold_addr", {addr_br, addr_um}, 10'd0);
        chk("hold_ena", ena_out, 1'b0);
        chk("hold_busy", busy, 1'b1);
        @(negedge clk);
        n = cyc;
        pad_sel_rst_n = 1'b1;
        push(1'b1, n + 6, 13'b01);
        repeat (10) @(negedge clk);
        chk("u0_selrst_addr", {u0_br, u0_um}, 10'd0);
        chk("u0_active_ena", u0_ena, 1'b1);
        chk("u0_active_busy", u0_busy, 1'b0);

        @(negedge clk);
        n = cyc;
        pad_sel_inc = 1'b1;
        adv();
        push(1'b0, n + 3, abun(ebr, eum));
        push(1'b1, n + 3, 13'b10);
        repeat (3) @(negedge clk);
        pad_sel_inc = 1'b0;
        @(posedge clk);
        #1;
        eum = 0;
        ebr = 0;
        push(1'b0, n + 4, abun(0, 0));
        push(1'b1, n + 4, 13'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n = cyc;
        rst_n = 1'b1;
        push(1'b1, n + 3, 13'b10);
        push(1'b1, n + 7, 13'b01);
        repeat (10) @(negedge clk);

        @(negedge clk);
        n = cyc;
        pad_ena = 1'b0;
        pad_sel_inc = 1'b1;
        adv();
        push(1'b0, n + 3, abun(ebr, eum));
        push(1'b1, n + 3, 13'd0);
        repeat (3) @(negedge clk);
        pad_sel_inc = 1'b0;
        repeat (6) @(negedge clk);

        chk("addr_queue_drained", aq.size(), 0);
        chk("ena_queue_drained", eq.size(), 0);
        chk("final_ena", ena_out, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tt_sel_ctrl.md
Name: tt_sel_ctrl

Overview:
- Design-select controller for the multi-branch TinyTapeout fabric; successor to the fixed single-branch select counter.
- Synchronises the three asynchronous control pads (select reset, select increment, enable) into the core clock domain.
- Maintains a two-level (branch, user-module) address over a parametrised G_X x G_Y grid, with wrap or saturate mode.
- Gates the design enable behind a settle window so a user module is only enabled once the address is stable; drives the branch muxes' address spine.

Parameters:
G_X, 16, user modules per branch (power of two not required, 1..32)
G_Y, 1, number of branches (1..32)
UM_W, 5, width of per-branch module address
BR_W, 5, width of branch address
SYNC_STAGES, 2, flip-flops in each pad synchroniser (>=2)
SETTLE, 4, cycles of stable address and enable before ena_out asserts (1..255)
WRAP, 1, 1: address wraps to 0 after last module; 0: saturates at last module

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
pad_sel_rst_n  in  1  async select-reset pad, active low
pad_sel_inc  in  1  async select-increment pad, rising edge counts
pad_ena  in  1  async design-enable pad, active high
addr_um  out  UM_W  module index within branch
addr_br  out  BR_W  branch index
br_sel  out  G_Y  one-hot branch select, derived from addr_br
ena_out  out  1  enable to selected user module
busy  out  1  high while settle window is running
at_last  out  1  address equals (G_Y-1, G_X-1)

Behaviour:
- Reset (rst_n low, async): all synchroniser flops 0, addr_um=0, addr_br=0, br_sel=1 (bit 0), ena_out=0, busy=0, at_last=(G_X==1 && G_Y==1).
- Synchronisers: each pad passes through SYNC_STAGES flops; s_rst_n, s_inc, s_ena are the last-stage outputs. One extra flop on s_inc gives inc_edge = s_inc & ~s_inc_d.
- Address update (registered, one cycle after inc_edge or s_rst_n low):
  - s_rst_n low: addr_um=0, addr_br=0; inc_edge is ignored (reset dominates).
  - inc_edge with s_rst_n high: if addr_um < G_X-1, addr_um+1. Otherwise addr_um=0 and addr_br+1, unless addr_br = G_Y-1.
  - At the last address: WRAP=1 gives (0,0); WRAP=0 holds the address.
  - No division or modulo: the module counter carries into the branch counter.
- br_sel and at_last are registered and updated in the same cycle as the address.
- Settle FSM, states IDLE, SETTLING, ACTIVE:
  - Any state -> IDLE when s_ena=0.
  - Any state -> SETTLING with counter loaded to SETTLE-1 on inc_edge or s_rst_n=0 while s_ena=1. ena_out drops in the same cycle the address changes.
  - IDLE -> SETTLING when s_ena=1 and s_rst_n=1; counter loaded to SETTLE-1.
  - SETTLING decrements each cycle. At 0 with no new event -> ACTIVE.
  - ena_out=1 only in ACTIVE (registered). busy=1 only in SETTLING.
- Latency, pad to ena_out with SYNC_STAGES=2, SETTLE=4: pad_ena rise -> ena_out high 2+1+4 = 7 cycles later.
- Simultaneous events: s_rst_n low beats inc_edge; s_ena low beats both for ena_out, while the address still updates.
- Reset mid-count or mid-settle returns everything to reset values asynchronously. No pending increment survives reset.

Decomposition:
- Shared package tt_pkg: settle state encoding (IDLE, SETTLING, ACTIVE), and the UM_W/BR_W defaults shared with tt_mux.
- One sub-module, tt_sync_edge: SYNC_STAGES synchroniser plus optional rising-edge output, instantiated three times (edge output used for pad_sel_inc only).

Test Plan:
- Reset value check (G_X=16, G_Y=2): assert then release rst_n -> addr (0,0), br_sel=2'b01, ena_out=0, busy=0, at_last=0.
- Carry across branches: 16 inc pulses, each held 3 clk high and 3 low -> after pulse 15 addr (0,15); after pulse 16 addr (1,0) and br_sel=2'b10.
- End of grid: 32 pulses with WRAP=1 -> addr (0,0), at_last seen high after pulse 31. Same with WRAP=0 -> addr stays (1,15), at_last=1.
- Settle gating: pad_ena high, no activity -> ena_out rises exactly 7 clk after pad edge. An inc pulse while ACTIVE -> ena_out low the cycle the address changes, busy high, ena_out back 4 clk after the edge is detected.
- Priority: pad_sel_rst_n low while inc pulses arrive -> address held at (0,0), ena_out stays 0. Release -> SETTLING, then ACTIVE after 4 clk.
- Async reset mid-settle: rst_n low with busy=1 -> all outputs to reset values with no clock edge required. After release, ena_out needs the full 7-cycle latency again.
